// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular fetch queue; registered storage, no bypass from push to head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  FQ_DEPTH = 4,
    parameter type entry_t  = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [FQ_DEPTH];
    entry_t          mem_d [FQ_DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is reset too so the head reads all zeros out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = (count_q == CW'(FQ_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, out-of-range halt, redirect/flush and the fetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 1024,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_halted
);

    logic [63:0]  pc_q, pc_d;
    logic         full, empty;
    logic         pop, push, fetch_ok;
    fetch_entry_t push_entry, head;

    // Compare in 65 bits so a PC near the top of the address space cannot wrap into range.
    assign fetch_halted = (({1'b0, pc_q} + 65'd3) >= 65'(IMEM_BYTES));

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign fetch_ok  = !fetch_halted && (!full || pop);
    assign push      = fetch_ok && !redirect_valid;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_instr;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~64'(INSTR_BYTES - 1);
        end else if (push) begin
            pc_d = pc_q + 64'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH),
        .entry_t  (fetch_entry_t)
    ) u_fetch_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     (push_entry),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    assign imem_addr = pc_q;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle-level reference model queues expected heads, a monitor checks them.
module tb_fetch_unit;

    localparam int          IMEM_BYTES = 1024;
    localparam int          DEPTH      = 4;
    localparam logic [63:0] RST_PC     = 64'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_halted;

    logic [31:0] mem [IMEM_BYTES/4];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [95:0]     sb[$];
    longint unsigned mpc  = RST_PC;
    int              mcnt = 0;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .IMEM_BYTES (IMEM_BYTES),
        .FQ_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_halted   (fetch_halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr < 64'(IMEM_BYTES)) imem_instr = mem[imem_addr[9:2]];
        else                             imem_instr = 32'hxxxx_xxxx;
    end

    function automatic bit in_range(longint unsigned pc);
        return pc <= longint'(IMEM_BYTES - 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: an entry is fetched whenever the PC is in range and the queue has room after any pop.
    always @(posedge clk) begin
        bit mpop;
        if (!reset_n) begin
            mpc = RST_PC; mcnt = 0; sb.delete();
        end else if (redirect_valid) begin
            mpc = redirect_pc & ~64'h3; mcnt = 0; sb.delete();
        end else begin
            mpop = (mcnt != 0) && out_ready;
            if (mpop) mcnt--;
            if (in_range(mpc) && mcnt < DEPTH) begin
                sb.push_back({mpc, mem[mpc >> 2]});
                mcnt++;
                mpc += 4;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [95:0] e;
        chk("out_valid", 64'(out_valid), 64'(mcnt != 0));
        chk("imem_addr", imem_addr, mpc);
        chk("fetch_halted", 64'(fetch_halted), 64'(!in_range(mpc)));
        if (reset_n && out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_head", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("head_pc", out_pc, e[95:32]);
                chk("head_instr", 64'(out_instr), 64'(e[31:0]));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < IMEM_BYTES/4; i++) mem[i] = $urandom;
        reset_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_halted", 64'(fetch_halted), 64'd0);
        tick(2);

        // Steady fetch
        reset_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("steady_pc0", out_pc, 64'd0);
        chk("steady_w0", 64'(out_instr), 64'(mem[0]));
        tick();
        chk("steady_pc1", out_pc, 64'd4);
        chk("steady_w1", 64'(out_instr), 64'(mem[1]));
        tick(8);

        // Backpressure
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        tick(6);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_addr", imem_addr, 64'd16);
        chk("bp_head", out_pc, 64'd0);
        out_ready = 1'b1;
        tick(8);

        // Redirect while full with a pop offered
        out_ready = 1'b0;
        tick(6);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", 64'(out_valid), 64'd0);
        chk("redir_addr", imem_addr, 64'h40);
        tick();
        chk("redir_head_pc", out_pc, 64'h40);
        chk("redir_head_w", 64'(out_instr), 64'(mem[16]));
        tick(4);

        // Run off the end of memory
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        tick();
        redirect_valid = 1'b0;
        chk("unalign_addr", imem_addr, 64'h100);
        chk("unalign_halt", 64'(fetch_halted), 64'd0);
        k = 0;
        while (!fetch_halted && k < 300) begin
            tick();
            k++;
        end
        chk("halt_set", 64'(fetch_halted), 64'd1);
        chk("halt_addr", imem_addr, 64'h400);
        tick(6);
        chk("halt_drained", 64'(out_valid), 64'd0);
        chk("halt_pc_hold", imem_addr, 64'h400);
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        chk("halt_clear", 64'(fetch_halted), 64'd0);
        tick(5);

        // Asynchronous reset between clock edges
        #6;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_addr", imem_addr, RST_PC);
        chk("async_out_pc", out_pc, 64'd0);
        tick();
        reset_n = 1'b1;
        tick(6);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 64'($urandom_range(0, 1100));
            tick();
        end
        redirect_valid = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end instruction fetch stage for the out-of-order pipeline. Owns the program counter, drives the combinational instruction memory's byte address, and captures each returned instruction with its PC into a small in-order fetch queue. Decode drains the queue through a valid/ready handshake. The back end steers fetch through a single redirect port (branch resolution or ROB flush), which also flushes the queue.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `IMEM_BYTES`, default 1024: instruction memory size in bytes; must be a power of two.
- `FQ_DEPTH`, default 4: fetch queue entries; must be a power of two and at least 2.

- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `imem_addr`, out, 64: byte address to the instruction memory; equals `pc`.
- `imem_instr`, in, 32: instruction returned combinationally for `imem_addr` in the same cycle.
- `redirect_valid`, in, 1: load a new PC and flush the queue.
- `redirect_pc`, in, 64: redirect target; bits [1:0] are forced to 0.
- `out_valid`, out, 1: the queue head is valid.
- `out_ready`, in, 1: decode accepts the head.
- `out_pc`, out, 64: PC of the head entry.
- `out_instr`, out, 32: instruction of the head entry.
- `fetch_halted`, out, 1: `pc` is out of range, so fetch is suspended.

## Operation
- Fetch window: `fetch_ok = !fetch_halted && (!full || pop)`.
  - `fetch_halted = (pc + 3 >= IMEM_BYTES)`, evaluated combinationally.
- Pop condition: `pop = out_valid && out_ready && !redirect_valid`.
- Each cycle with `fetch_ok` and no redirect:
  - push {`pc`, `imem_instr`} into the queue;
  - `pc <= pc + 4`, with 64-bit wraparound.
- While the queue is full with no pop, or while halted: `pc` holds, and `imem_addr` stays stable.
- Redirect has priority over everything else in its cycle:
  - `pc <= {redirect_pc[63:2], 2'b00}`;
  - queue count <= 0; pointers reset;
  - any push or pop in that cycle is discarded.
- Halt is not sticky. A redirect into range resumes fetch.
- The queue is a circular buffer:
  - `count` is `$clog2(FQ_DEPTH)+1` bits;
  - read and write pointers wrap modulo `FQ_DEPTH`.
- `out_valid = (count != 0)`. `out_pc` and `out_instr` show the entry at the read pointer.
- Simultaneous push and pop:
  - when full: count unchanged; both pointers advance;
  - when empty: not possible, because the data is registered (no bypass).
- Out-of-range `imem_instr` (X) is never stored, because of the halt check.

## Timing
- Reset, asynchronous, while `reset_n` = 0:
  - `pc = RESET_PC`, so `imem_addr = RESET_PC`;
  - count = 0, so `out_valid = 0`;
  - `out_pc` and `out_instr` read the reset contents of entry 0, which are all zeros;
  - `fetch_halted` reflects `RESET_PC`.
- Fetch-to-decode latency: 1 cycle.
  - The instruction at `pc` during cycle N is visible at the head in cycle N+1 if the queue was empty.
- Throughput: 1 instruction per cycle while decode pops each cycle.
- Redirect asserted in cycle N:
  - cycle N+1: `out_valid` = 0 and `imem_addr` = target;
  - cycle N+2: the target instruction is at the head (if in range).
- Reset asserted mid-operation: the queue is emptied and the PC is reloaded immediately. There is no partial state.

## Structure
- `fetch_pkg` holds:
  - `fetch_entry_t` (`pc` [63:0], `instr` [31:0]);
  - the `INSTR_BYTES` = 4 constant.
- Sub-module `fetch_queue`:
  - parameterised by `FQ_DEPTH` and the entry type;
  - ports: push, pop, flush, data in/out, full, empty;
  - contains no PC logic.
- `fetch_unit` contains the PC register, the halt compare, the redirect muxing, and the queue instance.

## Test plan
- Steady fetch with defaults, memory holding word i at address 4i, `out_ready` = 1:
  - cycle 1 head is {0, word0};
  - cycle 2 head is {4, word1};
  - one entry per cycle after that.
- Backpressure, `out_ready` = 0:
  - after 4 pushes `out_valid` = 1 and the queue is full;
  - `imem_addr` holds at 16;
  - release `out_ready`: the head sequence resumes at PC 0, then 4, 8, 12, 16 with no gap or duplicate.
- Redirect to 0x40 while full and `out_ready` = 1:
  - next cycle `out_valid` = 0 and `imem_addr` = 0x40;
  - the following cycle the head is {0x40, word16};
  - the popped-in-same-cycle entry is not delivered.
- Redirect to 0x103:
  - `imem_addr` = 0x100;
  - `fetch_halted` = 0 until PC reaches 0x3FC + 4;
  - at PC 0x400, `fetch_halted` = 1 with no pushes;
  - redirect to 0x0 clears `fetch_halted`.
- Assert `reset_n` low asynchronously mid-stream, between clock edges:
  - `out_valid` drops to 0 and `imem_addr` = `RESET_PC` immediately;
  - after release, fetch restarts from `RESET_PC`.
